uart_rx_buffer: RTL and testbench
=================================

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 115200, serial bit rate in bit/s.
REQ-003 SHALL have parameter BUFFER_SIZE, default 16, receive FIFO depth in bytes; power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line; idle level 1.
REQ-007 SHALL have port rd_en, input, 1, consumer pop request.
REQ-008 SHALL have port rd_data, output, 8, FIFO head byte.
REQ-009 SHALL have port empty, output, 1, FIFO holds no bytes.
REQ-010 SHALL have port full, output, 1, FIFO holds BUFFER_SIZE bytes.
REQ-011 SHALL have port count, output, $clog2(BUFFER_SIZE)+1, number of bytes held.
REQ-012 SHALL have port frame_error, output, 1, one-cycle pulse when a stop bit samples 0.
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when a byte is dropped because the FIFO is full.

Function
REQ-014 SHALL pass rx through a two-flop synchronizer, reset to 1, before any use.
REQ-015 SHALL use CLKS_PER_BIT = CLOCK_FREQ/BIT_RATE (integer division, truncated) and HALF = CLKS_PER_BIT/2.
REQ-016 SHALL implement an FSM with states IDLE, START, DATA and STOP.
REQ-017 In IDLE, a synchronized rx of 0 SHALL move to START and clear the bit-timer.
REQ-018 In START, after HALF cycles: rx=0 SHALL move to DATA; rx=1 (glitch) SHALL return to IDLE with no output.
REQ-019 In DATA, rx SHALL be sampled every CLKS_PER_BIT cycles, 8 samples, LSB first; after the 8th sample the FSM SHALL move to STOP.
REQ-020 In STOP, after CLKS_PER_BIT cycles: rx=1 SHALL push the byte; rx=0 SHALL pulse frame_error, discard the byte and wait in STOP until rx=1 before returning to IDLE.
REQ-021 The push SHALL occur in the stop-sample cycle; empty and count SHALL reflect it on the next cycle.
REQ-022 The FIFO SHALL be a circular buffer; read and write pointers SHALL wrap modulo BUFFER_SIZE.
REQ-023 rd_data SHALL present the head byte whenever empty=0 (first-word fall-through) and SHALL be 8'h00 when empty=1.
REQ-024 rd_en with empty=0 SHALL pop one byte at the clock edge; rd_en with empty=1 SHALL be ignored.
REQ-025 A push while full=1 and rd_en=0 SHALL drop the new byte, pulse overrun, and leave the contents unchanged.
REQ-026 A push and a pop in the same cycle SHALL both take effect, leaving count unchanged; when full=1 this SHALL NOT raise overrun.
REQ-027 A push and a pop in the same cycle with empty=1 SHALL perform the push only, giving count=1.
REQ-028 full SHALL equal (count==BUFFER_SIZE), and empty SHALL equal (count==0).

Reset
REQ-029 While reset=1, the following SHALL hold at the next edge: FSM=IDLE, timers and bit index=0, shift register=0, pointers=0, count=0, empty=1, full=0, rd_data=0, frame_error=0, overrun=0, synchronizer=1.
REQ-030 A reset asserted mid-frame SHALL abandon the frame with no push or error pulse; reception SHALL restart on the next falling edge after reset deasserts.

Verification (CLOCK_FREQ=1600, BIT_RATE=100, so CLKS_PER_BIT=16; BUFFER_SIZE=4)
REQ-031 Send 8'hA5 with a valid frame -> empty falls about 9.5 bit times (152 cycles ±3) after the start edge; rd_data=8'hA5, count=1; after rd_en, empty=1.
REQ-032 Drive a 4-cycle low glitch on rx -> no push, no frame_error, FSM back to IDLE.
REQ-033 Send 8'h3C with stop bit=0 -> single frame_error pulse, count stays 0; a following valid 8'h11 is received correctly.
REQ-034 Send 5 bytes 01..05 with no reads -> full=1 after the 4th byte, overrun pulses once on the 5th; pops return 01,02,03,04.
REQ-035 With the FIFO full, assert rd_en in the push cycle of a 5th byte -> no overrun, count stays 4, last pop returns the 5th byte; run 10 bytes through to check pointer wrap.
REQ-036 Assert reset during DATA bit 4 -> count=0, empty=1, no pulses; the next full frame 8'h7E is received intact.

Source files
------------

// File: rtl/uart_rx_buffer.sv
// -----------------------------------------------------------------------------
// uart_rx_buffer
//   8N1 UART receiver feeding a first-word-fall-through circular FIFO.
//   The serial input is double-flopped, framed by a four-state FSM that
//   samples mid-bit, and complete bytes are pushed into the FIFO on the
//   stop-bit sample.
//
// Parameters
//   CLOCK_FREQ   clock frequency in Hz
//   BIT_RATE     serial bit rate in bit/s
//   BUFFER_SIZE  FIFO depth in bytes (power of two, >= 2)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   rx           asynchronous serial line, idles high
//   rd_en        consumer pop request (ignored while empty)
//   rd_data      FIFO head byte, 8'h00 while empty
//   empty/full   FIFO occupancy flags
//   count        number of bytes held
//   frame_error  one-cycle pulse when a stop bit samples low
//   overrun      one-cycle pulse when a byte is dropped on a full FIFO
// -----------------------------------------------------------------------------
module uart_rx_buffer #(
    parameter int CLOCK_FREQ  = 50000000,
    parameter int BIT_RATE    = 115200,
    parameter int BUFFER_SIZE = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx,
    input  logic                         rd_en,
    output logic [7:0]                   rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(BUFFER_SIZE):0] count,
    output logic                         frame_error,
    output logic                         overrun
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int AW           = $clog2(BUFFER_SIZE);
    localparam int TW           = $clog2(CLKS_PER_BIT + 1);

    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_END = TW'(HALF - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(BUFFER_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic          rx_meta_q;
    logic          rx_sync_q;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          err_wait_q;   // bad stop bit seen, waiting for line to go idle
    logic          frame_error_q;

    logic [7:0]    mem_q [BUFFER_SIZE];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          overrun_q;

    logic          bit_done;
    logic          push_req;
    logic          push_ok;
    logic          pop;

    // Two-flop synchronizer; resets to the idle line level so a reset never
    // looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign bit_done = (timer_q == BIT_END);

    // Push is decided in the same cycle the good stop bit is sampled.
    assign push_req = (state_q == STOP) && !err_wait_q && bit_done && rx_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            err_wait_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            frame_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q    <= '0;
                    bit_idx_q  <= '0;
                    err_wait_q <= 1'b0;
                    if (!rx_sync_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    // Re-check the line at the middle of the start bit.
                    if (timer_q == HALF_END) begin
                        timer_q <= '0;
                        state_q <= rx_sync_q ? IDLE : DATA;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        timer_q   <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                STOP: begin
                    if (err_wait_q) begin
                        if (rx_sync_q) begin
                            err_wait_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end else if (bit_done) begin
                        timer_q <= '0;
                        if (rx_sync_q) begin
                            state_q <= IDLE;
                        end else begin
                            frame_error_q <= 1'b1;
                            err_wait_q    <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign pop     = rd_en && (count_q != '0);
    assign push_ok = push_req && ((count_q != DEPTH) || pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push_req && !push_ok;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH);
    assign count       = count_q;
    assign rd_data     = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

    localparam int DEPTH = 4;
    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       frame_error;
    logic       overrun;

    uart_rx_buffer #(
        .CLOCK_FREQ (1600),
        .BIT_RATE   (100),
        .BUFFER_SIZE(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse tallies observed on the DUT outputs
    int fe_cnt = 0;
    int ov_cnt = 0;
    always @(negedge clk) begin
        if (frame_error === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    // Reference model: byte queue plus expected pulse tallies
    logic [7:0] mq[$];
    int exp_fe = 0;
    int exp_ov = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One received frame as the receiver should interpret it.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic pop_same);
        if (!stop_ok) begin
            exp_fe++;
        end else begin
            if (pop_same && mq.size() > 0) void'(mq.pop_front());
            if (mq.size() < DEPTH) mq.push_back(b);
            else exp_ov++;
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (mq.size() > 0) ? mq[0] : 8'h00;
        check({tag, "_count"}, 32'(count), 32'(mq.size()));
        check({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
        check({tag, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
        check({tag, "_rd_data"}, 32'(rd_data), 32'(head));
        check({tag, "_frame_err"}, 32'(fe_cnt), 32'(exp_fe));
        check({tag, "_overrun"}, 32'(ov_cnt), 32'(exp_ov));
    endtask

    // Drives ncyc cycles of an 8N1 frame; optionally asserts rd_en in cycle
    // pop_at (capturing the head byte seen then). lat reports the cycle count
    // from the start edge to empty falling, if the FIFO started empty.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_at,
                              input int ncyc, output int lat, output logic [7:0] popped);
        logic start_empty;
        int   j;
        lat         = -1;
        popped      = 8'h00;
        start_empty = empty;
        for (int c = 0; c < ncyc; c++) begin
            j = c / CPB;
            if (j == 0) rx = 1'b0;
            else if (j <= 8) rx = b[j-1];
            else rx = stop_bit;
            rd_en = (c == pop_at);
            if (c == pop_at) popped = rd_data;
            @(posedge clk);
            #1;
            if (lat < 0 && start_empty && !empty) lat = c + 1;
        end
        rd_en = 1'b0;
        rx    = 1'b1;
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] exp;
        exp = (mq.size() > 0) ? mq.pop_front() : 8'h00;
        check(tag, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    initial begin
        int         lat;
        int         push_c;
        logic [7:0] popped;
        logic [7:0] b;
        logic [7:0] exp_head;

        reset = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        tick(3);
        check("reset_frame_error", 32'(frame_error), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick(5);
        check_state("reset");

        // Single valid frame and its arrival latency
        send_frame(8'hA5, 1'b1, -1, FRAME, lat, popped);
        model_frame(8'hA5, 1'b1, 1'b0);
        check("a5_latency_in_window", 32'(lat >= 149 && lat <= 155), 32'd1);
        push_c = (lat > 0) ? lat - 1 : 154;
        tick(6);
        check_state("a5");
        pop_one("a5_pop");
        check_state("a5_after_pop");

        // Short low glitch must not produce anything
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        check_state("glitch");
        b = 8'($urandom);
        send_frame(b, 1'b1, -1, FRAME, lat, popped);
        model_frame(b, 1'b1, 1'b0);
        tick(6);
        check_state("after_glitch");
        pop_one("after_glitch_pop");

        // Bad stop bit, then recovery
        send_frame(8'h3C, 1'b0, -1, FRAME, lat, popped);
        model_frame(8'h3C, 1'b0, 1'b0);
        tick(6);
        check_state("stop_err");
        send_frame(8'h11, 1'b1, -1, FRAME, lat, popped);
        model_frame(8'h11, 1'b1, 1'b0);
        tick(6);
        check_state("after_stop_err");
        pop_one("after_stop_err_pop");

        // Fill past capacity with no reads
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, -1, FRAME, lat, popped);
            model_frame(8'(i), 1'b1, 1'b0);
            tick(6);
            check_state($sformatf("fill%0d", i));
        end
        for (int i = 0; i < DEPTH; i++) pop_one($sformatf("fill_pop%0d", i));
        check_state("fill_drained");

        // Push and pop together on an empty FIFO: push only
        b = 8'($urandom);
        send_frame(b, 1'b1, push_c, FRAME, lat, popped);
        model_frame(b, 1'b1, 1'b1);
        tick(6);
        check_state("empty_push_pop");
        pop_one("empty_push_pop_pop");

        // Full FIFO with a pop in every push cycle; 10 bytes in total
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, -1, FRAME, lat, popped);
            model_frame(b, 1'b1, 1'b0);
            tick(6);
        end
        check_state("wrap_full");
        for (int i = 0; i < 6; i++) begin
            b        = 8'($urandom);
            exp_head = mq[0];
            send_frame(b, 1'b1, push_c, FRAME, lat, popped);
            model_frame(b, 1'b1, 1'b1);
            tick(6);
            check($sformatf("wrap_popped%0d", i), 32'(popped), 32'(exp_head));
            check_state($sformatf("wrap%0d", i));
        end
        for (int i = 0; i < DEPTH; i++) pop_one($sformatf("wrap_drain%0d", i));
        check_state("wrap_drained");

        // Reset in the middle of data bit 4 with a byte already buffered
        b = 8'($urandom);
        send_frame(b, 1'b1, -1, FRAME, lat, popped);
        model_frame(b, 1'b1, 1'b0);
        tick(6);
        check_state("pre_reset");
        send_frame(8'($urandom), 1'b1, -1, 5 * CPB + CPB / 2, lat, popped);
        reset = 1'b1;
        rx    = 1'b1;
        tick(2);
        reset = 1'b0;
        mq.delete();
        tick(200);
        check_state("mid_reset");
        send_frame(8'h7E, 1'b1, -1, FRAME, lat, popped);
        model_frame(8'h7E, 1'b1, 1'b0);
        tick(6);
        check_state("after_reset");
        pop_one("after_reset_pop");
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
